// File: rtl/rr_req_enc_pkg.sv
// Shared definitions for the round-robin request encoder.
// Active-level macros match stddef.vh when that header is absent.
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

package rr_req_enc_pkg;
  localparam int DEF_IN = 4;
  localparam bit ACT_HIGH = `High;
  localparam bit ACT_LOW = `Low;
endpackage

// File: rtl/rr_req_enc_if.sv
// Valid/ready index stream between encoder and consumer.
import rr_req_enc_pkg::*;

interface rr_req_enc_if #(
  parameter int IN = DEF_IN
);
  logic          valid;
  logic          ready;
  logic [IN-1:0] idx;

  modport master (output valid, output idx, input ready);
  modport slave (input valid, input idx, output ready);
endinterface

// File: rtl/rr_pri_enc.sv
// Rotating priority encoder: first set bit of vec at or above ptr,
// wrapping modulo OUT.
import rr_req_enc_pkg::*;

module rr_pri_enc #(
  parameter int IN  = DEF_IN,
  parameter int OUT = 1 << IN
) (
  input  logic [OUT-1:0] vec,
  input  logic [IN-1:0]  ptr,
  output logic [IN-1:0]  sel,
  output logic           found
);

  logic [2*OUT-1:0] dbl;
  logic [OUT-1:0]   rot;
  logic [IN-1:0]    pe;

  assign dbl = {vec, vec} >> ptr;
  assign rot = dbl[OUT-1:0];

  always_comb begin
    pe = '0;
    for (int i = OUT - 1; i >= 0; i--) begin
      if (rot[i]) pe = IN'(i);
    end
  end

  // IN-bit add wraps modulo OUT
  assign sel   = pe + ptr;
  assign found = |vec;

endmodule

// File: rtl/rr_req_enc.sv
// Multi-hot request vector to binary index stream, one index per
// handshake, issued round-robin from a pending register.
import rr_req_enc_pkg::*;

module rr_req_enc #(
  parameter int IN  = DEF_IN,
  parameter int OUT = 1 << IN,
  parameter bit ACT = `High
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic [OUT-1:0] req,
  rr_req_enc_if.master   out,
  output logic [OUT-1:0] pend,
  output logic           empty
);

  logic [OUT-1:0] r;
  logic [OUT-1:0] cand;
  logic [IN-1:0]  ptr;
  logic [IN-1:0]  s;
  logic [IN-1:0]  idx_q;
  logic           valid_q;
  logic           found;
  logic           load;

  assign r    = ACT ? req : ~req;
  assign cand = pend | r;
  assign load = !valid_q || out.ready;

  rr_pri_enc #(
    .IN  (IN),
    .OUT (OUT)
  ) u_pri (
    .vec   (cand),
    .ptr   (ptr),
    .sel   (s),
    .found (found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= '0;
      ptr     <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else if (clr) begin
      pend    <= '0;
      ptr     <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else if (load) begin
      if (found) begin
        valid_q <= 1'b1;
        idx_q   <= s;
        ptr     <= s + IN'(1);
        pend    <= cand & ~(OUT'(1) << s);
      end else begin
        valid_q <= 1'b0;
        pend    <= cand;
      end
    end else begin
      // output stalled: keep collecting strobes
      pend <= cand;
    end
  end

  assign out.valid = valid_q;
  assign out.idx   = idx_q;
  assign empty     = (pend == '0) && !valid_q;

endmodule

// File: tb/tb_rr_req_enc.sv
// Directed self-checking bench for rr_req_enc (active-high and
// active-low instances).
import rr_req_enc_pkg::*;

module tb_rr_req_enc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] req_lo = '1;
  logic [15:0] pend, pend_lo;
  logic        empty, empty_lo;
  int          checks = 0;
  int          passed = 0;

  rr_req_enc_if #(.IN(4)) ifh ();
  rr_req_enc_if #(.IN(4)) ifl ();

  rr_req_enc #(.IN(4), .OUT(16), .ACT(ACT_HIGH)) u_hi (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .req   (req),
    .out   (ifh.master),
    .pend  (pend),
    .empty (empty)
  );

  rr_req_enc #(.IN(4), .OUT(16), .ACT(ACT_LOW)) u_lo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .req   (req_lo),
    .out   (ifl.master),
    .pend  (pend_lo),
    .empty (empty_lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifh.ready = 1'b1;
    ifl.ready = 1'b1;
    #1;
    checks++;
    if ({ifh.valid, ifh.idx, pend, empty} !== {1'b0, 4'd0, 16'h0, 1'b1})
      $display("FAIL reset_in v=%b i=%0d p=%h e=%b want 0 0 0000 1",
               ifh.valid, ifh.idx, pend, empty);
    else passed++;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({ifh.valid, ifh.idx, pend, empty} !== {1'b0, 4'd0, 16'h0, 1'b1})
        $display("FAIL idle%0d v=%b i=%0d p=%h e=%b want 0 0 0000 1",
                 c, ifh.valid, ifh.idx, pend, empty);
      else passed++;
    end
    ifh.ready = 1'b0;
    req = 16'h0001;
    tick();
    req = 16'h00F0;
    tick();
    req = '0;
    checks++;
    if ({ifh.valid, pend} !== {1'b1, 16'h00F0})
      $display("FAIL burst_pend v=%b p=%h want 1 00f0", ifh.valid, pend);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ifh.valid, ifh.idx, pend, empty} !== {1'b0, 4'd0, 16'h0, 1'b1})
      $display("FAIL async_rst v=%b i=%0d p=%h e=%b want 0 0 0000 1",
               ifh.valid, ifh.idx, pend, empty);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    ifh.ready = 1'b1;
    tick();
  endtask

  task automatic test_onehot();
    for (int i = 0; i < 16; i++) begin
      req = 16'h1 << i;
      tick();
      checks++;
      if (ifh.valid !== 1'b1 || ifh.idx !== 4'(i))
        $display("\033[1;31mFAIL onehot%0d v=%b idx=%0d want 1 %0d\033[0m",
                 i, ifh.valid, ifh.idx, i);
      else begin
        passed++;
        $display("\033[1;36mok onehot%0d idx=%0d\033[0m", i, ifh.idx);
      end
    end
    req = '0;
    tick();
    checks++;
    if (ifh.valid !== 1'b0)
      $display("FAIL sweep_drain v=%b want 0", ifh.valid);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp [4];
    exp = '{4'd0, 4'd15, 4'd0, 4'd1};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req = 16'h8001;
    tick();
    checks++;
    if (ifh.valid !== 1'b1 || ifh.idx !== exp[0])
      $display("FAIL rr0 v=%b idx=%0d want 1 %0d", ifh.valid, ifh.idx, exp[0]);
    else passed++;
    req = '0;
    tick();
    checks++;
    if (ifh.valid !== 1'b1 || ifh.idx !== exp[1])
      $display("FAIL rr1 v=%b idx=%0d want 1 %0d", ifh.valid, ifh.idx, exp[1]);
    else passed++;
    req = 16'h0003;
    tick();
    checks++;
    if (ifh.valid !== 1'b1 || ifh.idx !== exp[2])
      $display("FAIL rr2 v=%b idx=%0d want 1 %0d", ifh.valid, ifh.idx, exp[2]);
    else passed++;
    req = '0;
    tick();
    checks++;
    if (ifh.valid !== 1'b1 || ifh.idx !== exp[3])
      $display("FAIL rr3 v=%b idx=%0d want 1 %0d", ifh.valid, ifh.idx, exp[3]);
    else passed++;
    tick();
    checks++;
    if (ifh.valid !== 1'b0 || empty !== 1'b1)
      $display("FAIL rr_drain v=%b e=%b want 0 1", ifh.valid, empty);
    else passed++;
  endtask

  task automatic test_back_pressure();
    ifh.ready = 1'b0;
    req = 16'h0024;
    for (int c = 0; c < 4; c++) begin
      tick();
      req = '0;
      checks++;
      if ({ifh.valid, ifh.idx, pend} !== {1'b1, 4'd2, 16'h0020})
        $display("FAIL bp_hold%0d v=%b i=%0d p=%h want 1 2 0020",
                 c, ifh.valid, ifh.idx, pend);
      else passed++;
    end
    ifh.ready = 1'b1;
    tick();
    checks++;
    if ({ifh.valid, ifh.idx, pend} !== {1'b1, 4'd5, 16'h0})
      $display("FAIL bp_rel v=%b i=%0d p=%h want 1 5 0000",
               ifh.valid, ifh.idx, pend);
    else passed++;
    tick();
    checks++;
    if (ifh.valid !== 1'b0 || empty !== 1'b1)
      $display("FAIL bp_drain v=%b e=%b want 0 1", ifh.valid, empty);
    else passed++;
  endtask

  task automatic test_rereq_clr();
    ifh.ready = 1'b0;
    req = 16'h0008;
    tick();
    tick();
    req = '0;
    checks++;
    if ({ifh.valid, ifh.idx, pend} !== {1'b1, 4'd3, 16'h0008})
      $display("FAIL rereq_hold v=%b i=%0d p=%h want 1 3 0008",
               ifh.valid, ifh.idx, pend);
    else passed++;
    ifh.ready = 1'b1;
    tick();
    checks++;
    if ({ifh.valid, ifh.idx, pend} !== {1'b1, 4'd3, 16'h0})
      $display("FAIL rereq_again v=%b i=%0d p=%h want 1 3 0000",
               ifh.valid, ifh.idx, pend);
    else passed++;
    tick();
    checks++;
    if (ifh.valid !== 1'b0)
      $display("FAIL rereq_drain v=%b want 0", ifh.valid);
    else passed++;
    ifh.ready = 1'b0;
    req = 16'h0001;
    tick();
    req = 16'h0FF0;
    tick();
    checks++;
    if (pend !== 16'h0FF0)
      $display("FAIL clr_setup p=%h want 0ff0", pend);
    else passed++;
    clr = 1'b1;
    req = 16'h0001;
    tick();
    clr = 1'b0;
    req = '0;
    checks++;
    if ({ifh.valid, ifh.idx, pend, empty} !== {1'b0, 4'd0, 16'h0, 1'b1})
      $display("FAIL clr v=%b i=%0d p=%h e=%b want 0 0 0000 1",
               ifh.valid, ifh.idx, pend, empty);
    else passed++;
    ifh.ready = 1'b1;
  endtask

  task automatic test_act_low();
    int xfers = 0;
    checks++;
    if (ifl.valid !== 1'b0 || empty_lo !== 1'b1)
      $display("FAIL lo_idle v=%b e=%b want 0 1", ifl.valid, empty_lo);
    else passed++;
    req_lo = 16'hFFDF;
    tick();
    req_lo = 16'hFFFF;
    checks++;
    if ({ifl.valid, ifl.idx, pend_lo} !== {1'b1, 4'd5, 16'h0})
      $display("FAIL lo_issue v=%b i=%0d p=%h want 1 5 0000",
               ifl.valid, ifl.idx, pend_lo);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      if (ifl.valid && ifl.ready) xfers++;
      tick();
    end
    checks++;
    if (xfers !== 1 || empty_lo !== 1'b1)
      $display("FAIL lo_xfers n=%0d e=%b want 1 1", xfers, empty_lo);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_round_robin();
    test_back_pressure();
    test_rereq_clr();
    test_act_low();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
